multicycle_control: RTL and testbench

//  Parametrised multicycle RISC-V control FSM sequencing IF/ID/EX/MEM/WB/PC_UPD for lw, sw, R-type, I-ALU, beq.
//  Per-class state skipping, ready handshakes to instruction/data memory, wait timeout, single-step mode,

---
 rtl/multicycle_control_pkg.sv | 65 ++++++
 rtl/multicycle_control_wait_timer.sv | 47 ++++
 rtl/multicycle_control.sv | 202 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// multicycle_control_pkg
//   Shared definitions for the multicycle RISC-V control unit:
//     - state_t        : FSM state encoding. This is the value driven on the
//                        'estado' output and consumed by every datapath stage.
//     - OP_*           : RV32I major opcodes handled by this control unit.
//     - instr_class_t  : instruction class derived from the opcode in ID.
//     - classify()     : opcode -> class helper (CLS_BAD for anything else).
//     - class_uses_mem / class_writes_reg : path-selection helpers.
// ----------------------------------------------------------------------------
package multicycle_control_pkg;

   // Encoding is externally visible through 'estado', so keep these values
   // fixed: IF=0 ID=1 EX=2 MEM=3 WB=4 PC_UPD=5 HALT=6 ERR=7.
   typedef enum logic [2:0] {
      ST_IF     = 3'd0,
      ST_ID     = 3'd1,
      ST_EX     = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_PC_UPD = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERR    = 3'd7
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // R-type and I-ALU take the same path through the FSM, so they share a
   // single class.
   typedef enum logic [2:0] {
      CLS_LW  = 3'd0,
      CLS_SW  = 3'd1,
      CLS_ALU = 3'd2,
      CLS_BEQ = 3'd3,
      CLS_BAD = 3'd4
   } instr_class_t;

   function automatic instr_class_t classify(input logic [6:0] op);
      instr_class_t cls;
      case (op)
         OP_LW:   cls = CLS_LW;
         OP_SW:   cls = CLS_SW;
         OP_R:    cls = CLS_ALU;
         OP_I:    cls = CLS_ALU;
         OP_BEQ:  cls = CLS_BEQ;
         default: cls = CLS_BAD;
      endcase
      return cls;
   endfunction

   // Loads and stores are the only classes that visit MEM.
   function automatic logic class_uses_mem(input instr_class_t cls);
      return (cls == CLS_LW) || (cls == CLS_SW);
   endfunction

   // Loads and ALU operations are the only classes that visit WB.
   function automatic logic class_writes_reg(input instr_class_t cls);
      return (cls == CLS_LW) || (cls == CLS_ALU);
   endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// ----------------------------------------------------------------------------
// multicycle_control_wait_timer
//   Counts consecutive cycles spent waiting on a memory ready. One instance is
//   shared by the instruction-fetch wait and the data-memory wait, which are
//   never active at the same time.
//
//   Ports
//     clk      in  1  clock
//     rst_n    in  1  asynchronous reset, active-low
//     clear    in  1  restart the count (asserted when a wait state is entered)
//     enable   in  1  this cycle is a waiting cycle (request high, no ready)
//     expired  out 1  this waiting cycle is the WAIT_MAX-th one in a row
//
//   The counter holds the number of waiting cycles already completed, so
//   'expired' is raised during the WAIT_MAX-th waiting cycle itself. A ready
//   arriving in that same cycle removes 'enable' and therefore wins.
// ----------------------------------------------------------------------------
module multicycle_control_wait_timer #(
   parameter int WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
   localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

   logic [CW-1:0] cnt_q;

   // Saturates at LAST; the FSM leaves the wait state when expired fires, so
   // saturation only matters as a guard against wrap-around.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
//   Multicycle RISC-V control FSM. Sequences IF/ID/EX/MEM/WB/PC_UPD for lw,
//   sw, R-type, I-ALU and beq, skipping the states a class does not need.
//   Adds memory wait timeouts, a single-step mode and a retired-instruction
//   counter. 'estado' is the state and drives every datapath stage.
//
//   Parameters
//     PC_W       width of pc
//     NUM_INSTR  program length; a fetch with pc >= NUM_INSTR halts
//     WAIT_MAX   maximum waiting cycles on imem_ready/dmem_ready before ERR
//     CNT_W      width of the retired counter
//
//   Ports
//     clk          in   1      clock, rising edge
//     rst_n        in   1      asynchronous reset, active-low
//     pc           in   PC_W   current instruction index
//     opcode       in   7      decoded opcode, valid from ID onward
//     imem_ready   in   1      instruction word valid this cycle
//     dmem_ready   in   1      data access complete this cycle
//     step_mode    in   1      1 = fetch only on a step pulse
//     step         in   1      one-cycle pulse allowing one fetch
//     estado       out  3      current state (see multicycle_control_pkg)
//     imem_req     out  1      fetch request
//     dmem_req     out  1      data access request (MEM only)
//     regwrite_en  out  1      register write strobe (WB only)
//     pc_en        out  1      PC update strobe (PC_UPD only)
//     halted       out  1      program ended (HALT, absorbing)
//     error        out  1      timeout or illegal opcode (ERR, absorbing)
//     retired      out  CNT_W  completed instructions, wraps
//
//   Handshake: a request (imem_req / dmem_req) stays high from the first
//   cycle of its wait until the cycle in which the matching ready is seen
//   high; that cycle completes the transfer and the FSM moves on at the next
//   edge. A ready seen while the request is low is ignored. If WAIT_MAX
//   consecutive request cycles pass without ready, the FSM enters ERR.
// ----------------------------------------------------------------------------
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int NUM_INSTR = 11,
   parameter int WAIT_MAX  = 15,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PC_W-1:0]  pc,
   input  logic [6:0]       opcode,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             step_mode,
   input  logic             step,
   output logic [2:0]       estado,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             regwrite_en,
   output logic             pc_en,
   output logic             halted,
   output logic             error,
   output logic [CNT_W-1:0] retired
);

   state_t             state_q;
   state_t             state_d;
   instr_class_t       cls_q;       // class captured in ID, steers EX and MEM
   instr_class_t       id_cls;
   logic               fetch_pend_q;
   logic               fetch_en;
   logic               pc_done;
   logic               waiting;
   logic               tmr_clear;
   logic               tmr_expired;
   logic [CNT_W-1:0]   retired_q;

   assign pc_done = (pc >= PC_W'(NUM_INSTR));
   assign id_cls  = classify(opcode);

   // A fetch may start when free-running, or on a step pulse seen in IF.
   // Once started it stays enabled until imem_ready, so later step pulses
   // and step_mode changes do not disturb an ongoing fetch.
   assign fetch_en = fetch_pend_q || !step_mode || step;

   assign waiting = ((state_q == ST_IF) && !pc_done && fetch_en && !imem_ready) ||
                    ((state_q == ST_MEM) && !dmem_ready);

   // The timer restarts whenever a wait state is freshly entered.
   assign tmr_clear = (state_d != state_q) &&
                      ((state_d == ST_IF) || (state_d == ST_MEM));

   multicycle_control_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .enable  (waiting),
      .expired (tmr_expired)
   );

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IF;
      end else begin
         state_q <= state_d;
      end
   end

   // Side registers: fetch enable latch, captured class, retired counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pend_q <= 1'b0;
         cls_q        <= CLS_BAD;
         retired_q    <= '0;
      end else begin
         // Only an enabled fetch that is still waiting keeps the latch set.
         fetch_pend_q <= (state_q == ST_IF) && (state_d == ST_IF) && fetch_en;
         if (state_q == ST_ID) begin
            cls_q <= id_cls;
         end
         if (state_q == ST_PC_UPD) begin
            retired_q <= retired_q + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IF: begin
            // End of program takes priority over stepping and readiness.
            if (pc_done) begin
               state_d = ST_HALT;
            end else if (fetch_en) begin
               if (imem_ready) begin
                  state_d = ST_ID;
               end else if (tmr_expired) begin
                  state_d = ST_ERR;
               end
            end
         end
         ST_ID: begin
            state_d = (id_cls == CLS_BAD) ? ST_ERR : ST_EX;
         end
         ST_EX: begin
            if (class_uses_mem(cls_q)) begin
               state_d = ST_MEM;
            end else if (class_writes_reg(cls_q)) begin
               state_d = ST_WB;
            end else if (cls_q == CLS_BEQ) begin
               state_d = ST_PC_UPD;
            end else begin
               state_d = ST_ERR;
            end
         end
         ST_MEM: begin
            if (dmem_ready) begin
               state_d = (cls_q == CLS_LW) ? ST_WB : ST_PC_UPD;
            end else if (tmr_expired) begin
               state_d = ST_ERR;
            end
         end
         ST_WB:     state_d = ST_PC_UPD;
         ST_PC_UPD: state_d = ST_IF;
         ST_HALT:   state_d = ST_HALT;
         ST_ERR:    state_d = ST_ERR;
         default:   state_d = ST_ERR;
      endcase
   end

   // ---------------------------------------------------------------------
   // Output decode: every strobe is tied to exactly one state.
   // ---------------------------------------------------------------------
   always_comb begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      regwrite_en = 1'b0;
      pc_en       = 1'b0;
      halted      = 1'b0;
      error       = 1'b0;
      case (state_q)
         // rst_n term keeps the fetch request quiet while reset is held.
         ST_IF:     imem_req    = rst_n && !pc_done && fetch_en;
         ST_MEM:    dmem_req    = 1'b1;
         ST_WB:     regwrite_en = 1'b1;
         ST_PC_UPD: pc_en       = 1'b1;
         ST_HALT:   halted      = 1'b1;
         ST_ERR:    error       = 1'b1;
         default:   ;
      endcase
   end

   assign estado  = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// ----------------------------------------------------------------------------
// tb_multicycle_control
//   Self-checking bench for multicycle_control. Inputs are driven 1 time unit
//   after the rising edge and outputs are sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_multicycle_control;

   localparam int NUM_INSTR = 11;
   localparam int WAIT_MAX  = 15;

   localparam logic [6:0] T_LW  = 7'b0000011;
   localparam logic [6:0] T_SW  = 7'b0100011;
   localparam logic [6:0] T_R   = 7'b0110011;
   localparam logic [6:0] T_I   = 7'b0010011;
   localparam logic [6:0] T_BEQ = 7'b1100011;

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;
   localparam logic [2:0] S_PC  = 3'd5;
   localparam logic [2:0] S_HLT = 3'd6;
   localparam logic [2:0] S_ERR = 3'd7;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic [6:0]  opcode;
   logic        imem_ready, dmem_ready, step_mode, step;
   logic [2:0]  estado;
   logic        imem_req, dmem_req, regwrite_en, pc_en, halted, error;
   logic [15:0] retired;
   logic [5:0]  strb;

   always #5 clk = ~clk;

   assign strb = {imem_req, dmem_req, regwrite_en, pc_en, halted, error};

   multicycle_control #(
      .PC_W      (32),
      .NUM_INSTR (NUM_INSTR),
      .WAIT_MAX  (WAIT_MAX),
      .CNT_W     (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc          (pc),
      .opcode      (opcode),
      .imem_ready  (imem_ready),
      .dmem_ready  (dmem_ready),
      .step_mode   (step_mode),
      .step        (step),
      .estado      (estado),
      .imem_req    (imem_req),
      .dmem_req    (dmem_req),
      .regwrite_en (regwrite_en),
      .pc_en       (pc_en),
      .halted      (halted),
      .error       (error),
      .retired     (retired)
   );

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [6:0]  opcode;
      logic [31:0] pc;
      logic        imem_ready;
      logic        dmem_ready;
      logic [15:0] exp_ret;
   } stim_t;

   typedef struct {
      logic [6:0] opcode;
      int         lat;
      int         n_dmem;
      int         n_rw;
   } vec_t;

   stim_t       stim_q[$];
   logic [2:0]  exp_q[$];
   logic [15:0] model_ret;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      rst_n      = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      step_mode  = 1'b0;
      step       = 1'b0;
      pc         = 32'd0;
      opcode     = T_R;
      #1;
      check("rst_estado", estado, S_IF);
      check("rst_strobes", strb, 6'b0);
      check("rst_retired", retired, 16'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      model_ret = 16'd0;
   endtask

   task automatic push_cyc(input logic [6:0] op, input logic [31:0] pcv,
                           input logic ir, input logic dr, input logic [2:0] st);
      stim_t s;
      s.opcode     = op;
      s.pc         = pcv;
      s.imem_ready = ir;
      s.dmem_ready = dr;
      s.exp_ret    = model_ret;
      stim_q.push_back(s);
      exp_q.push_back(st);
   endtask

   // Reference model: one instruction expands to its list of cycles. The
   // fetch waits idly cycles, the data access waits ddly cycles.
   task automatic push_instr(input logic [6:0] op, input int idly, input int ddly,
                             input logic [31:0] pcv);
      for (int i = 0; i <= idly; i++) push_cyc(op, pcv, i == idly, 1'b0, S_IF);
      push_cyc(op, pcv, 1'b0, 1'b0, S_ID);
      push_cyc(op, pcv, 1'b0, 1'b0, S_EX);
      if (op == T_LW || op == T_SW)
         for (int j = 0; j <= ddly; j++) push_cyc(op, pcv, 1'b0, j == ddly, S_MEM);
      if (op == T_LW || op == T_R || op == T_I) push_cyc(op, pcv, 1'b0, 1'b0, S_WB);
      push_cyc(op, pcv, 1'b0, 1'b0, S_PC);
      model_ret = model_ret + 16'd1;
   endtask

   task automatic run_queue();
      stim_t      s;
      logic [2:0] e;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         e = exp_q.pop_front();
         opcode     = s.opcode;
         pc         = s.pc;
         imem_ready = s.imem_ready;
         dmem_ready = s.dmem_ready;
         #1;
         check("estado", estado, e);
         check("strobes", strb, {e == S_IF, e == S_MEM, e == S_WB, e == S_PC, 2'b00});
         check("retired", retired, s.exp_ret);
         next_cycle();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
   endtask

   // Hold ready idle until the FSM leaves the wait state it is in; returns
   // how many cycles the given state was seen with its request high.
   task automatic count_wait(input logic [2:0] st, output int n);
      n = 0;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (estado == S_ERR) break;
         if (estado == st && (imem_req || dmem_req)) n++;
         next_cycle();
      end
   endtask

   // ---------------- test ----------------
   vec_t vecs[5];

   initial begin
      int          n;
      int          cyc, nd, nw, np;
      logic [15:0] r0;
      logic [15:0] dr;
      logic [6:0]  ops[5];

      vecs[0] = '{opcode: T_LW,  lat: 6, n_dmem: 1, n_rw: 1};
      vecs[1] = '{opcode: T_SW,  lat: 5, n_dmem: 1, n_rw: 0};
      vecs[2] = '{opcode: T_R,   lat: 5, n_dmem: 0, n_rw: 1};
      vecs[3] = '{opcode: T_I,   lat: 5, n_dmem: 0, n_rw: 1};
      vecs[4] = '{opcode: T_BEQ, lat: 4, n_dmem: 0, n_rw: 0};
      ops = '{T_LW, T_SW, T_R, T_I, T_BEQ};

      // ---- latency table, readies high immediately ----
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         opcode     = vecs[i].opcode;
         pc         = 32'(i);
         imem_ready = 1'b1;
         dmem_ready = 1'b1;
         r0 = retired;
         cyc = 0; nd = 0; nw = 0; np = 0;
         do begin
            #1;
            nd += int'(dmem_req);
            nw += int'(regwrite_en);
            np += int'(pc_en);
            next_cycle();
            cyc++;
         end while (estado != S_IF && cyc < 20);
         dr = retired - r0;
         check("tbl_latency", cyc, vecs[i].lat);
         check("tbl_dmem_cycles", nd, vecs[i].n_dmem);
         check("tbl_regwrite_cycles", nw, vecs[i].n_rw);
         check("tbl_pc_en_cycles", np, 1);
         check("tbl_retired_delta", dr, 1);
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;

      // ---- directed traces: lw, beq, R, fetch waits, ready on last cycle ----
      apply_reset();
      push_instr(T_LW, 0, 0, 0);
      push_instr(T_BEQ, 0, 0, 1);
      push_instr(T_R, 0, 0, 2);
      push_instr(T_R, 3, 0, 3);
      push_instr(T_SW, 0, WAIT_MAX - 1, 4);
      push_instr(T_I, WAIT_MAX - 1, 0, 5);
      push_instr(T_BEQ, 0, 0, NUM_INSTR - 1);
      run_queue();

      // ---- randomized program against the model ----
      apply_reset();
      for (int k = 0; k < 40; k++) begin
         int idly, ddly;
         idly = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
         ddly = ($urandom_range(0, 7) == 0) ? WAIT_MAX - 1 : $urandom_range(0, 3);
         push_instr(ops[$urandom_range(0, 4)], idly, ddly, 32'($urandom_range(0, NUM_INSTR - 1)));
      end
      run_queue();

      // ---- dmem_ready never arrives ----
      apply_reset();
      opcode     = T_LW;
      imem_ready = 1'b1;
      next_cycle();
      imem_ready = 1'b0;
      count_wait(S_MEM, n);
      check("dmem_timeout_cycles", n, WAIT_MAX);
      check("dmem_timeout_estado", estado, S_ERR);
      check("dmem_timeout_strobes", strb, 6'b000001);
      dmem_ready = 1'b1;
      imem_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         #1;
         check("err_absorbing", estado, S_ERR);
      end

      // ---- imem_ready never arrives ----
      apply_reset();
      count_wait(S_IF, n);
      check("imem_timeout_cycles", n, WAIT_MAX);
      check("imem_timeout_estado", estado, S_ERR);
      check("imem_timeout_error", error, 1'b1);

      // ---- illegal opcode ----
      apply_reset();
      opcode     = 7'b1111111;
      imem_ready = 1'b1;
      next_cycle();
      #1;
      check("illegal_in_id", estado, S_ID);
      next_cycle();
      #1;
      check("illegal_estado", estado, S_ERR);
      check("illegal_strobes", strb, 6'b000001);
      imem_ready = 1'b0;

      // ---- end of program ----
      apply_reset();
      pc         = NUM_INSTR;
      imem_ready = 1'b1;
      #1;
      check("halt_no_fetch", imem_req, 1'b0);
      for (int c = 0; c < 20; c++) begin
         next_cycle();
         #1;
         check("halt_estado", estado, S_HLT);
         check("halt_strobes", strb, 6'b000010);
      end
      imem_ready = 1'b0;
      pc         = 32'd0;

      // ---- single-step mode ----
      apply_reset();
      step_mode = 1'b1;
      pc        = 32'd2;
      opcode    = T_R;
      for (int c = 0; c < 10; c++) begin
         #1;
         check("step_idle_estado", estado, S_IF);
         check("step_idle_req", imem_req, 1'b0);
         next_cycle();
      end
      step = 1'b1;
      #1;
      check("step_pulse_req", imem_req, 1'b1);
      next_cycle();
      step = 1'b0;
      #1;
      check("step_latched_req", imem_req, 1'b1);
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      next_cycle();
      #1;
      check("step_in_id", estado, S_ID);
      step = 1'b1;          // pulse outside IF must not start another fetch
      next_cycle();
      step = 1'b0;
      for (int c = 0; c < 30; c++) next_cycle();
      #1;
      check("step_retired_one", retired, 16'd1);
      check("step_back_idle", estado, S_IF);
      check("step_idle_after", imem_req, 1'b0);
      step_mode  = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;

      // ---- reset asserted during MEM of sw ----
      apply_reset();
      push_instr(T_LW, 0, 0, 0);
      run_queue();
      opcode     = T_SW;
      imem_ready = 1'b1;
      next_cycle();
      imem_ready = 1'b0;
      next_cycle();
      next_cycle();
      #1;
      check("sw_in_mem", estado, S_MEM);
      check("sw_mem_req", dmem_req, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_estado", estado, S_IF);
      check("midrst_dmem_req", dmem_req, 1'b0);
      check("midrst_retired", retired, 16'd0);
      check("midrst_strobes", strb, 6'b0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      model_ret = 16'd0;
      #1;
      check("release_no_partial", {dmem_req, regwrite_en, pc_en}, 3'b000);
      push_instr(T_SW, 0, 0, 1);
      push_instr(T_R, 1, 0, 2);
      run_queue();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
